// File: rtl/a0_trace_fifo.sv
// Records every change of the CPU a0 register as a {value, timestamp} entry in a
// small FIFO that a slower reader drains over a valid/ready handshake.
module a0_trace_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TS_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   a0_i,
  input  logic                    en_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic [TS_WIDTH-1:0]     out_ts_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o,
  output logic [7:0]              drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [TS_WIDTH-1:0]   mem_ts   [DEPTH];

  logic [TS_WIDTH-1:0]   ts_q;
  logic [DATA_WIDTH-1:0] prev_a0_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  overflow_q;
  logic [7:0]            drop_cnt_q;

  logic change_c;
  logic push_req_c;
  logic pop_c;
  logic full_c;
  logic do_push_c;
  logic drop_c;

  // A push into a full FIFO still lands when the same edge pops the head.
  always_comb begin
    change_c   = (a0_i != prev_a0_q);
    push_req_c = en_i & change_c;
    pop_c      = out_valid_o & out_ready_i;
    full_c     = (count_q == CNT_W'(DEPTH));
    do_push_c  = push_req_c & (~full_c | pop_c);
    drop_c     = push_req_c & full_c & ~pop_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      prev_a0_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q      <= ts_q + TS_WIDTH'(1);
      prev_a0_q <= a0_i;
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop_c) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push_c) begin
      mem_data[wr_ptr_q] <= a0_i;
      mem_ts[wr_ptr_q]   <= ts_q;
    end
  end

  always_comb begin
    out_valid_o = (count_q != '0);
    out_data_o  = out_valid_o ? mem_data[rd_ptr_q] : '0;
    out_ts_o    = out_valid_o ? mem_ts[rd_ptr_q]   : '0;
    count_o     = count_q;
    overflow_o  = overflow_q;
    drop_cnt_o  = drop_cnt_q;
  end

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Scoreboard bench for a0_trace_fifo: stimulus queues expected entries, a negedge
// monitor compares every popped head entry; a second instance covers timestamp wrap.
module tb_a0_trace_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] a0;
  logic        en;
  logic        ready;
  logic        valid;
  logic [31:0] data;
  logic [15:0] ts;
  logic [4:0]  count;
  logic        ovf;
  logic [7:0]  drops;

  logic        rst_b;
  logic [31:0] a0_b;
  logic        valid_b;
  logic [31:0] data_b;
  logic [3:0]  ts_b;
  logic [4:0]  count_b;
  logic        ovf_b;
  logic [7:0]  drops_b;

  typedef struct {
    logic [31:0] d;
    logic [15:0] t;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  a0_trace_fifo #(.DATA_WIDTH(32), .DEPTH(16), .TS_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a0_i(a0), .en_i(en),
    .out_valid_o(valid), .out_ready_i(ready), .out_data_o(data), .out_ts_o(ts),
    .count_o(count), .overflow_o(ovf), .drop_cnt_o(drops)
  );

  a0_trace_fifo #(.DATA_WIDTH(32), .DEPTH(16), .TS_WIDTH(4)) dut_ts4 (
    .clk(clk), .rst(rst_b), .a0_i(a0_b), .en_i(1'b1),
    .out_valid_o(valid_b), .out_ready_i(1'b0), .out_data_o(data_b), .out_ts_o(ts_b),
    .count_o(count_b), .overflow_o(ovf_b), .drop_cnt_o(drops_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_push(input logic [31:0] d);
    ent_t e;
    e.d = d;
    e.t = 16'(cyc);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    a0    = '0;
    en    = 1'b1;
    ready = 1'b0;
    tick();
    rst = 1'b0;
    cyc = 0;
    sb.delete();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf",   64'(ovf),   64'd0);
    chk("rst_drops", 64'(drops), 64'd0);
  endtask

  task automatic drain();
    int k;
    ready = 1'b1;
    k = 0;
    while (count != 0 && k < 40) begin
      tick();
      k++;
    end
    ready = 1'b0;
    chk("drain_done", 64'(count), 64'd0);
    chk("sb_left", 64'(sb.size()), 64'd0);
  endtask

  // Every accepted head entry must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(data), 64'hDEAD_BEEF);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("pop_data", 64'(data), 64'(e.d));
        chk("pop_ts",   64'(ts),   64'(e.t));
      end
    end
  end

  initial begin
    rst   = 1'b1;
    rst_b = 1'b1;
    a0    = '0;
    a0_b  = '0;
    en    = 1'b1;
    ready = 1'b0;

    // Idle: a0 held at zero records nothing.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", 64'(valid), 64'd0);
      chk("idle_count", 64'(count), 64'd0);
      chk("idle_ovf",   64'(ovf),   64'd0);
    end

    // Single change at timestamp 3, then one pop.
    do_reset();
    repeat (3) tick();
    a0 = 32'h5;
    sb.push_back('{d: 32'h5, t: 16'd3});
    tick();
    chk("one_valid", 64'(valid), 64'd1);
    chk("one_data",  64'(data),  64'h5);
    chk("one_ts",    64'(ts),    64'd3);
    chk("one_count", 64'(count), 64'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("one_count_after", 64'(count), 64'd0);
    chk("one_valid_after", 64'(valid), 64'd0);
    chk("empty_data_zero", 64'(data),  64'd0);
    chk("empty_ts_zero",   64'(ts),    64'd0);

    // 20 changes into a 16-deep FIFO: 4 drops.
    do_reset();
    for (int v = 1; v <= 20; v++) begin
      a0 = 32'(v);
      if (v <= 16) expect_push(32'(v));
      tick();
    end
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_flag",  64'(ovf),   64'd1);
    chk("ovf_drops", 64'(drops), 64'd4);
    drain();
    chk("ovf_sticky", 64'(ovf), 64'd1);

    // Full FIFO with simultaneous pop and push: no drop, new value at tail.
    do_reset();
    for (int v = 1; v <= 16; v++) begin
      a0 = 32'(v);
      expect_push(32'(v));
      tick();
    end
    chk("full_count", 64'(count), 64'd16);
    a0    = 32'h77;
    ready = 1'b1;
    expect_push(32'h77);
    tick();
    ready = 1'b0;
    chk("fullpp_count", 64'(count), 64'd16);
    chk("fullpp_drops", 64'(drops), 64'd0);
    chk("fullpp_ovf",   64'(ovf),   64'd0);
    drain();

    // Changes while disabled are neither recorded nor dropped.
    do_reset();
    en = 1'b0;
    a0 = 32'h1; tick();
    a0 = 32'h2; tick();
    a0 = 32'h3; tick();
    en = 1'b1;
    tick();
    tick();
    chk("en_count", 64'(count), 64'd0);
    chk("en_drops", 64'(drops), 64'd0);
    a0 = 32'h4;
    expect_push(32'h4);
    tick();
    chk("en_count_4", 64'(count), 64'd1);
    chk("en_data_4",  64'(data),  64'h4);
    drain();

    // 4-bit timestamp wraps: change at cycle 17 is stamped 1.
    tick();
    rst_b = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    a0_b = 32'h9;
    tick();
    chk("wrap_valid", 64'(valid_b), 64'd1);
    chk("wrap_data",  64'(data_b),  64'h9);
    chk("wrap_ts",    64'(ts_b),    64'd1);
    for (int v = 10; v <= 13; v++) begin
      a0_b = 32'(v);
      tick();
    end
    chk("wrap_count5", 64'(count_b), 64'd5);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("wrap_rst_count", 64'(count_b), 64'd0);
    chk("wrap_rst_valid", 64'(valid_b), 64'd0);
    chk("wrap_rst_ovf",   64'(ovf_b),   64'd0);
    chk("wrap_rst_drops", 64'(drops_b), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/a0_trace_fifo.md
Name: a0_trace_fifo

Overview:
- Downstream consumer of the CPU's a0 result register output.
- Watches a0 every cycle. Each time a0 changes, it records an entry {value, cycle timestamp} in an internal FIFO.
- A display or host-side reader drains the FIFO over a valid/ready interface.
- Lets the testbench or Vbuddy front end see every a0 update (e.g. light-sequence steps) without polling at CPU clock rate.

Parameters:
- DATA_WIDTH, 32, width of a0 and of stored values.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- TS_WIDTH, 16, width of the free-running cycle timestamp.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- a0_i  input  DATA_WIDTH  CPU a0 output.
- en_i  input  1  capture enable; when 0, changes are not recorded.
- out_valid_o  output  1  head entry available.
- out_ready_i  input  1  consumer accepts head entry this cycle.
- out_data_o  output  DATA_WIDTH  head entry a0 value.
- out_ts_o  output  TS_WIDTH  head entry timestamp.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_o  output  1  sticky: at least one change was dropped.
- drop_cnt_o  output  8  number of dropped changes, saturating at 255.

Behaviour:
- Reset (rst=1 at a clk edge) clears to 0: timestamp counter, prev_a0, rd/wr pointers, count_o, overflow_o, drop_cnt_o. Storage contents need not be cleared.
- Reset while non-empty or while a push/pop is in progress discards everything; the cycle after reset, out_valid_o=0.
- Timestamp counter:
  - Increments by 1 every non-reset cycle.
  - Wraps from 2^TS_WIDTH-1 to 0; no flag on wrap.
  - A pushed entry carries the counter value of the cycle in which the change is seen (pre-increment value).
- Change detect:
  - prev_a0 registers a0_i every non-reset cycle, regardless of en_i.
  - change = (a0_i != prev_a0).
  - First cycle after reset compares against 0, so a non-zero a0_i is recorded.
- push_req = en_i & change.
- pop = out_valid_o & out_ready_i.
- out_valid_o = (count_o != 0), driven purely from registers.
- out_data_o / out_ts_o show the head entry from registered storage. When empty, both are forced to 0.
- Latency: an entry pushed at edge N is visible at the outputs (out_valid_o=1) after edge N; it can be popped at edge N+1 at the earliest.
- Occupancy update per edge:
  - push only (not full): write at wr_ptr, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - push and pop, count between 1 and DEPTH-1: both happen, count unchanged.
  - push and pop when full: both happen (pop frees the slot in the same edge), count stays DEPTH, no drop.
  - push and pop when empty: pop is impossible (valid=0); push succeeds, count becomes 1.
  - push when full with no pop: entry discarded, overflow_o set to 1 (sticky until rst), drop_cnt_o incremented, saturating at 255.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. Full/empty is taken from count_o, not pointer compare.
- out_ready_i when not valid has no effect.
- Changes while en_i=0 are never recorded and never counted as drops.

Test Plan:
- Reset, then a0_i held at 0 for 10 cycles -> out_valid_o=0, count_o=0, overflow_o=0 throughout.
- After reset, a0_i=0x5 at cycle 3 (timestamp 3), out_ready_i=0 -> next cycle out_valid_o=1, out_data_o=0x5, out_ts_o=3, count_o=1. Then out_ready_i=1 for one cycle -> count_o=0, out_valid_o=0.
- a0_i toggles 1,2,3,...,20 on consecutive cycles, DEPTH=16, out_ready_i=0:
  - count_o reaches 16.
  - overflow_o=1, drop_cnt_o=4.
  - Draining yields 1..16 in order with consecutive timestamps.
- FIFO full (16 entries), a0_i changes while out_ready_i=1 in the same cycle -> count_o stays 16, drop_cnt_o unchanged, new value appears at the tail on drain.
- en_i=0 while a0_i changes 0x1->0x2->0x3, then en_i=1 with a0_i steady -> no entries. Next change to 0x4 pushes one entry with value 0x4.
- Set TS_WIDTH=4, let the counter pass 15, change a0_i at cycle 17 -> recorded out_ts_o=1. Assert rst with 5 entries queued -> next cycle count_o=0, out_valid_o=0, overflow_o=0, drop_cnt_o=0.
